mdu_hilo: RTL



---
 rtl/mdu_pkg.sv | 22 ++
 rtl/mdu_hilo_if.sv | 26 ++
 rtl/mdu_divider.sv | 89 ++++++++
 rtl/mdu_hilo.sv | 122 ++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: op codes, divide length
// and the divider state encoding.
package mdu_pkg;

    localparam int unsigned MDU_DIV_CYCLES = 32;
    localparam int unsigned OP_W           = 3;

    localparam logic [OP_W-1:0] OP_NOP   = 3'd0;
    localparam logic [OP_W-1:0] OP_MULT  = 3'd1;
    localparam logic [OP_W-1:0] OP_MULTU = 3'd2;
    localparam logic [OP_W-1:0] OP_DIV   = 3'd3;
    localparam logic [OP_W-1:0] OP_DIVU  = 3'd4;
    localparam logic [OP_W-1:0] OP_MTHI  = 3'd5;
    localparam logic [OP_W-1:0] OP_MTLO  = 3'd6;
    localparam logic [OP_W-1:0] OP_MFHI  = 3'd7;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } div_state_t;

endpackage

// File: rtl/mdu_hilo_if.sv
// Core <-> MDU connection: op request, GPR operands, and HI/LO/status back.
interface mdu_hilo_if
    import mdu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic [OP_W-1:0]  op;
    logic [WIDTH-1:0] rs_data;
    logic [WIDTH-1:0] rt_data;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] mf_data;

    modport master (
        output start, op, rs_data, rt_data,
        input  busy, done, hi, lo, mf_data
    );

    modport slave (
        input  start, op, rs_data, rt_data,
        output busy, done, hi, lo, mf_data
    );
endinterface

// File: rtl/mdu_divider.sv
// Unsigned restoring divider, one quotient bit per clock over WIDTH clocks.
// o_done_c / o_quotient_c / o_remainder_c are valid in the final RUN cycle so
// the parent can commit on the same edge the divider returns to IDLE.
module mdu_divider
    import mdu_pkg::*;
#(
    parameter int unsigned WIDTH = MDU_DIV_CYCLES
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_dividend,
    input  logic [WIDTH-1:0] i_divisor,
    output logic             o_busy,
    output logic             o_done_c,
    output logic [WIDTH-1:0] o_quotient_c,
    output logic [WIDTH-1:0] o_remainder_c
);
    localparam int unsigned CNT_W = $clog2(WIDTH);

    div_state_t       r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [WIDTH-1:0] r_rem, w_rem_nxt;
    logic [WIDTH-1:0] r_quo, w_quo_nxt;
    logic [WIDTH-1:0] r_dvs, w_dvs_nxt;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH-1:0] w_diff;
    logic             w_ge;

    // One restoring step: shift in the next dividend bit and try to subtract.
    always_comb begin
        w_shift       = {r_rem, r_quo[WIDTH-1]};
        w_ge          = (w_shift >= {1'b0, r_dvs});
        w_diff        = w_shift[WIDTH-1:0] - r_dvs;
        o_remainder_c = w_ge ? w_diff : w_shift[WIDTH-1:0];
        o_quotient_c  = {r_quo[WIDTH-2:0], w_ge};
    end

    assign o_busy = (r_state == ST_RUN);

    // State and datapath registers; reset aborts any divide in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_rem   <= '0;
            r_quo   <= '0;
            r_dvs   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_rem   <= w_rem_nxt;
            r_quo   <= w_quo_nxt;
            r_dvs   <= w_dvs_nxt;
        end
    end

    // Next-state: load operands on start, iterate down to count 0, then finish.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_rem_nxt   = r_rem;
        w_quo_nxt   = r_quo;
        w_dvs_nxt   = r_dvs;
        o_done_c    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_state_nxt = ST_RUN;
                    w_cnt_nxt   = CNT_W'(WIDTH - 1);
                    w_rem_nxt   = '0;
                    w_quo_nxt   = i_dividend;
                    w_dvs_nxt   = i_divisor;
                end
            end
            ST_RUN: begin
                w_rem_nxt = o_remainder_c;
                w_quo_nxt = o_quotient_c;
                w_cnt_nxt = r_cnt - 1'b1;
                if (r_cnt == '0) begin
                    o_done_c    = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

endmodule

// File: rtl/mdu_hilo.sv
// Multiply/divide unit holding the architectural HI/LO registers.
// Multiplies and MTHI/MTLO complete at the accept edge; divides run on the
// iterative divider and stall the core via busy.
// Build option: MDU_DIV_EN includes the divider; without it DIV/DIVU are NOPs
// and busy/done stay low.
module mdu_hilo
    import mdu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic       clk,
    input  logic       reset,
    mdu_hilo_if.slave  bus
);
    localparam int unsigned PROD_W = 2 * WIDTH;

    logic [WIDTH-1:0]  r_hi;
    logic [WIDTH-1:0]  r_lo;
    logic              w_busy;
    logic              w_accept;
    logic [PROD_W-1:0] w_prod_s;
    logic [PROD_W-1:0] w_prod_u;

    assign w_accept = bus.start && !w_busy;

    // Full-width products from sign- or zero-extended operands.
    always_comb begin
        w_prod_s = PROD_W'($signed({{WIDTH{bus.rs_data[WIDTH-1]}}, bus.rs_data}) *
                           $signed({{WIDTH{bus.rt_data[WIDTH-1]}}, bus.rt_data}));
        w_prod_u = {{WIDTH{1'b0}}, bus.rs_data} * {{WIDTH{1'b0}}, bus.rt_data};
    end

`ifdef MDU_DIV_EN
    logic             w_div_signed;
    logic             w_div_go;
    logic [WIDTH-1:0] w_dvd_mag;
    logic [WIDTH-1:0] w_dvs_mag;
    logic             w_div_busy;
    logic             w_div_done_c;
    logic [WIDTH-1:0] w_quo;
    logic [WIDTH-1:0] w_rem;
    logic [WIDTH-1:0] w_quo_fix;
    logic [WIDTH-1:0] w_rem_fix;
    logic             r_neg_q;
    logic             r_neg_r;
    logic             r_done;

    // Divide launch: signed ops feed magnitudes; a zero divisor never starts.
    always_comb begin
        w_div_signed = (bus.op == OP_DIV);
        w_div_go     = w_accept && ((bus.op == OP_DIV) || (bus.op == OP_DIVU)) &&
                       (bus.rt_data != '0);
        w_dvd_mag    = (w_div_signed && bus.rs_data[WIDTH-1]) ? -bus.rs_data : bus.rs_data;
        w_dvs_mag    = (w_div_signed && bus.rt_data[WIDTH-1]) ? -bus.rt_data : bus.rt_data;
        w_quo_fix    = r_neg_q ? -w_quo : w_quo;
        w_rem_fix    = r_neg_r ? -w_rem : w_rem;
    end

    mdu_divider #(
        .WIDTH (WIDTH)
    ) u_div (
        .clk           (clk),
        .reset         (reset),
        .i_start       (w_div_go),
        .i_dividend    (w_dvd_mag),
        .i_divisor     (w_dvs_mag),
        .o_busy        (w_div_busy),
        .o_done_c      (w_div_done_c),
        .o_quotient_c  (w_quo),
        .o_remainder_c (w_rem)
    );

    // Result sign fix-ups captured at launch, plus the registered done pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= w_div_done_c;
            if (w_div_go) begin
                r_neg_q <= w_div_signed && (bus.rs_data[WIDTH-1] ^ bus.rt_data[WIDTH-1]);
                r_neg_r <= w_div_signed && bus.rs_data[WIDTH-1];
            end
        end
    end

    assign w_busy   = w_div_busy;
    assign bus.done = r_done;
`else
    assign w_busy   = 1'b0;
    assign bus.done = 1'b0;
`endif

    // HI/LO update: immediate ops at the accept edge, divide results at commit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_hi <= '0;
            r_lo <= '0;
        end else if (w_accept) begin
            case (bus.op)
                OP_MULT:  {r_hi, r_lo} <= w_prod_s;
                OP_MULTU: {r_hi, r_lo} <= w_prod_u;
                OP_MTHI:  r_hi <= bus.rs_data;
                OP_MTLO:  r_lo <= bus.rs_data;
                default:  ;
            endcase
        end
`ifdef MDU_DIV_EN
        else if (w_div_done_c) begin
            r_hi <= w_rem_fix;
            r_lo <= w_quo_fix;
        end
`endif
    end

    assign bus.busy    = w_busy;
    assign bus.hi      = r_hi;
    assign bus.lo      = r_lo;
    assign bus.mf_data = (bus.op == OP_MFHI) ? r_hi : '0;

endmodule
